// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer
//   Captures the packed A_param x C_param result bus of the matrix multiplier
//   on a load strobe, then streams the elements out in row-major order, one
//   per valid/ready transfer, tagged with their row/column indices.
//
// Ports:
//   clk       - single clock, rising-edge active
//   rst       - asynchronous active-high reset
//   load      - capture request, honoured only while idle
//   Result    - packed matrix, element (r,c) at [r*C_param*8 + c*8 +: 8]
//   busy      - high from the cycle after an accepted load to the final transfer
//   out_valid - element present on out_data/out_row/out_col
//   out_ready - consumer accepts the element at a rising edge with out_valid
//   out_data  - current element value
//   out_row   - row index of the current element (zero-extended)
//   out_col   - column index of the current element (zero-extended)
//   out_last  - current element is (A_param-1, C_param-1)
//   done      - one-cycle pulse after the final transfer
module matrix_result_streamer #(
  parameter int A_param = 3,
  parameter int C_param = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [A_param*C_param*8-1:0] Result,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_data,
  output logic [7:0]                   out_row,
  output logic [7:0]                   out_col,
  output logic                         out_last,
  output logic                         done
);

  localparam int N  = A_param * C_param;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [7:0] LAST_ROW = 8'(A_param - 1);
  localparam logic [7:0] LAST_COL = 8'(C_param - 1);
  localparam bit SINGLE_ELEM = (N == 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state_r;
  logic [N*8-1:0]   buf_r;
  // Row-major order means the flat element index simply counts up, so the
  // buffer is addressed by idx_r while row/col are tracked alongside it.
  logic [IW-1:0]    idx_r;
  logic [7:0]       row_r;
  logic [7:0]       col_r;
  logic [7:0]       data_r;
  logic             valid_r;
  logic             busy_r;
  logic             last_r;
  logic             done_r;

  logic [IW-1:0]    next_idx_s;
  logic [7:0]       next_row_s;
  logic [7:0]       next_col_s;
  logic             next_last_s;
  logic [7:0]       next_data_s;

  // Position and contents of the element that follows the one presented now.
  always_comb begin
    next_idx_s = idx_r + IW'(1'b1);
    if (col_r == LAST_COL) begin
      next_col_s = 8'd0;
      next_row_s = row_r + 8'd1;
    end else begin
      next_col_s = col_r + 8'd1;
      next_row_s = row_r;
    end
    next_last_s = (next_row_s == LAST_ROW) && (next_col_s == LAST_COL);
    next_data_s = buf_r[{next_idx_s, 3'b000} +: 8];
  end

  // Capture/stream state machine; every output comes straight from a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      buf_r   <= {(N*8){1'b0}};
      idx_r   <= {IW{1'b0}};
      row_r   <= 8'd0;
      col_r   <= 8'd0;
      data_r  <= 8'd0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      last_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (load) begin
            buf_r   <= Result;
            idx_r   <= {IW{1'b0}};
            row_r   <= 8'd0;
            col_r   <= 8'd0;
            data_r  <= Result[7:0];
            last_r  <= SINGLE_ELEM;
            valid_r <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= SEND;
          end else begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        SEND: begin
          // load is deliberately ignored here: no queueing, no restart.
          if (out_ready) begin
            if (last_r) begin
              valid_r <= 1'b0;
              busy_r  <= 1'b0;
              last_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= IDLE;
            end else begin
              idx_r  <= next_idx_s;
              row_r  <= next_row_s;
              col_r  <= next_col_s;
              data_r <= next_data_s;
              last_r <= next_last_s;
            end
          end else begin
            // Stalled consumer: everything presented stays put.
            valid_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign out_row   = row_r;
  assign out_col   = col_r;
  assign out_last  = last_r;
  assign done      = done_r;

endmodule

// File: doc/matrix_result_streamer.md
Name: matrix_result_streamer

Overview:
- Sequential reader for the flattened A_param x C_param matrix bus produced by the team's combinational matrix multiplier.
- On a load strobe it captures the whole packed result bus into an internal buffer.
- It then streams the elements out one per transfer, in row-major order, over a valid/ready handshake, tagged with row/column indices.
- It sits between the multiplier output and any narrow downstream consumer (UART framer, memory writer, display driver).

Parameters:
- A_param, 3, number of matrix rows (1..256)
- C_param, 8, number of matrix columns (1..256)

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- rst  input  1  asynchronous, active-high reset
- load  input  1  capture request; sampled only in IDLE
- Result  input  A_param*C_param*8  packed matrix; element (r,c) occupies bits [r*C_param*8 + c*8 +: 8], bit 0 = LSB
- busy  output  1  high from the cycle after an accepted load until the final transfer completes
- out_valid  output  1  element present on out_data
- out_ready  input  1  consumer accepts the element when out_valid && out_ready at a rising edge
- out_data  output  8  current element value
- out_row  output  8  row index of current element
- out_col  output  8  column index of current element
- out_last  output  1  high while the presented element is (A_param-1, C_param-1)
- done  output  1  one-cycle pulse after the final transfer

Behaviour:
- Reset (asynchronous, immediate, any state, including mid-stream):
  - state = IDLE
  - out_valid, busy, done, out_last = 0
  - out_data, out_row, out_col = 0
  - capture buffer cleared to 0
  - Any stream in progress is abandoned; there is no resume after reset.
- FSM states:
  - IDLE:
    - out_valid = 0, busy = 0.
    - If load = 1 at an edge: copy Result into the buffer, set row = col = 0, go to SEND.
  - SEND:
    - busy = 1, out_valid = 1.
    - out_data = buffer element (row, col); out_row = row; out_col = col.
    - out_last = (row == A_param-1 && col == C_param-1).
    - Transfer at an edge with out_ready = 1:
      - If not last: col+1; on col == C_param-1 wrap col to 0 and increment row.
      - If last: go to IDLE and assert done for exactly the next cycle.
    - Transfer with out_ready = 0: hold. out_data, out_row, out_col and out_last stay stable while out_valid = 1.
- Latency:
  - load sampled at edge k gives the first element valid after edge k.
  - With out_ready held high, one element per cycle; a full matrix takes A_param*C_param cycles.
  - done rises at the edge after the last transfer.
- Result is sampled only at the accepted load edge. Changes on Result during SEND do not affect streamed data.
- load during SEND is ignored (no queueing, no restart).
- load in the done cycle: the state is already IDLE, so it is accepted and a new stream starts on the next cycle, with done still pulsing once.
- out_valid never drops without a transfer, except on reset.
- Indices are zero-extended into the 8-bit out_row/out_col. Parameters outside 1..256 are unsupported.
- 1x1 matrix: out_last = 1 on the first and only element.

Test Plan:
- A_param=2, C_param=2, Result={8'h44,8'h33,8'h22,8'h11}, load pulse, out_ready=1:
  - data 11,22,33,44 on four consecutive cycles
  - (row,col) = (0,0),(0,1),(1,0),(1,1)
  - out_last only with 44
  - done one cycle after the 44 transfer; busy low afterwards
- Same setup, out_ready low for 3 cycles while 22 is presented: out_data=22, out_col=1, out_valid=1 held stable all 3 cycles; then 33 follows.
- Load while busy, with Result changed to all 8'hFF mid-stream: no restart; the original 11,22,33,44 sequence completes unchanged.
- Assert rst after 2 transfers: out_valid, busy and out_data go to 0 immediately, before the next clock edge. After release, out_valid stays 0 until a new load, which restarts at (0,0).
- Defaults 3x8, element (r,c)=r*8+c, out_ready=1: 24 transfers with values 0..23; out_last on (2,7)=23; done on cycle 25.
- load asserted in the done cycle: a second stream begins on the next cycle, and done pulses exactly once per completed stream.
